// File: rtl/axi_slave_read_channel.sv
// AXI read-channel slave: accepts one AR burst at a time, reads it from a 1-cycle-latency memory
// port and returns the beats through a 2-entry buffer. Define AXI_SLAVE_RANGE_CHECK_EN for the range check.
module axi_slave_read_channel #(
   parameter int ADDR_WIDTH         = 32,
   parameter int READ_CHANNEL_WIDTH = 4,
   parameter int READ_BURST_LEN     = 8,
   parameter int MEM_DEPTH          = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ARVALID,
   output logic                          ARREADY,
   input  logic [ADDR_WIDTH-1:0]         ARADDR,
   input  logic [READ_BURST_LEN-1:0]     ARLEN,
   input  logic [2:0]                    ARSIZE,
   input  logic [1:0]                    ARBURST,
   output logic                          RVALID,
   input  logic                          RREADY,
   output logic [READ_CHANNEL_WIDTH-1:0] RDATA,
   output logic                          RLAST,
   output logic [1:0]                    RRESP,
   output logic                          mem_rd_en,
   output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
   input  logic [READ_CHANNEL_WIDTH-1:0] mem_rd_data,
   output logic                          busy
);

   typedef enum logic {S_IDLE, S_BURST} state_e;

   typedef struct packed {
      logic [READ_CHANNEL_WIDTH-1:0] data;
      logic [1:0]                    resp;
      logic                          last;
   } beat_t;

   localparam int                  CW          = READ_BURST_LEN + 1;
   localparam logic [1:0]          RESP_OKAY   = 2'b00;
   localparam logic [1:0]          RESP_SLVERR = 2'b10;
   localparam logic [1:0]          BURST_FIXED = 2'b00;
   localparam logic [1:0]          BURST_INCR  = 2'b01;
   localparam logic [ADDR_WIDTH:0] MEM_DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   state_e                    state_q, state_d;
   logic                      ready_en_q, ready_en_d;
   logic [ADDR_WIDTH-1:0]     base_q, base_d;
   logic [READ_BURST_LEN-1:0] len_q, len_d;
   logic [1:0]                burst_q, burst_d;
   logic [CW-1:0]             issue_cnt_q, issue_cnt_d;
   logic                      infl_valid_q, infl_valid_d;
   logic                      infl_err_q, infl_err_d;
   logic                      infl_last_q, infl_last_d;
   beat_t                     fifo_q [2];
   beat_t                     fifo_d [2];
   logic                      wr_ptr_q, wr_ptr_d;
   logic                      rd_ptr_q, rd_ptr_d;
   logic [1:0]                occ_q, occ_d;

   logic                  arready, rvalid, pop, push, ar_hs;
   logic                  burst_ok, range_err, issue, issue_err;
   logic [ADDR_WIDTH-1:0] issue_addr;
   beat_t                 head, push_beat;

   // ARSIZE is accepted but has no effect on a word-addressed memory.
   logic unused_ok;
   assign unused_ok = ^{ARSIZE, MEM_DEPTH_W};

   always_comb begin
      arready    = (state_q == S_IDLE) && ready_en_q;
      rvalid     = (occ_q != 2'd0);
      head       = fifo_q[rd_ptr_q];
      pop        = rvalid && RREADY;
      push       = infl_valid_q;
      ar_hs      = ARVALID && arready;
      burst_ok   = (burst_q == BURST_FIXED) || (burst_q == BURST_INCR);
      issue_addr = (burst_q == BURST_FIXED) ? base_q : base_q + ADDR_WIDTH'(issue_cnt_q);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
      range_err  = ({1'b0, issue_addr} >= MEM_DEPTH_W);
`else
      range_err  = 1'b0;
`endif
      // Buffered beats plus the one in flight, less the one leaving now, must leave room.
      issue      = (state_q == S_BURST) && (issue_cnt_q <= {1'b0, len_q}) &&
                   (({1'b0, occ_q} + {2'b00, infl_valid_q}) < (3'd2 + {2'b00, pop}));
      issue_err  = !burst_ok || range_err;
   end

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      state_d      = state_q;
      ready_en_d   = 1'b1;
      base_d       = base_q;
      len_d        = len_q;
      burst_d      = burst_q;
      issue_cnt_d  = issue_cnt_q;
      infl_valid_d = issue;
      infl_err_d   = issue_err;
      infl_last_d  = (issue_cnt_q == {1'b0, len_q});
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q + {1'b0, push} - {1'b0, pop};
      fifo_d       = fifo_q;

      push_beat.data = infl_err_q ? '0 : mem_rd_data;
      push_beat.resp = infl_err_q ? RESP_SLVERR : RESP_OKAY;
      push_beat.last = infl_last_q;

      if (push) begin
         fifo_d[wr_ptr_q] = push_beat;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (issue) begin
         issue_cnt_d = issue_cnt_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (ar_hs) begin
               base_d      = ARADDR;
               len_d       = ARLEN;
               burst_d     = ARBURST;
               issue_cnt_d = '0;
               state_d     = S_BURST;
            end
         end
         S_BURST: begin
            if (pop && head.last) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ready_en_q   <= 1'b0;
         base_q       <= '0;
         len_q        <= '0;
         burst_q      <= '0;
         issue_cnt_q  <= '0;
         infl_valid_q <= 1'b0;
         infl_err_q   <= 1'b0;
         infl_last_q  <= 1'b0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         occ_q        <= '0;
      end else begin
         state_q      <= state_d;
         ready_en_q   <= ready_en_d;
         base_q       <= base_d;
         len_q        <= len_d;
         burst_q      <= burst_d;
         issue_cnt_q  <= issue_cnt_d;
         infl_valid_q <= infl_valid_d;
         infl_err_q   <= infl_err_d;
         infl_last_q  <= infl_last_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
      end
   end

   // NOTE: buffer storage is not reset; occupancy is, and the outputs are gated by it.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   assign ARREADY     = arready;
   assign RVALID      = rvalid;
   assign RDATA       = rvalid ? head.data : '0;
   assign RRESP       = rvalid ? head.resp : RESP_OKAY;
   assign RLAST       = rvalid && head.last;
   assign mem_rd_en   = issue && !issue_err;
   assign mem_rd_addr = mem_rd_en ? issue_addr : '0;
   assign busy        = (state_q == S_BURST);

endmodule

// File: tb/tb_axi_slave_read_channel.sv
// Self-checking bench for axi_slave_read_channel: directed and random bursts against a queue-based
// reference model, with a behavioural 1-cycle-latency memory.
module tb_axi_slave_read_channel;

   localparam int AW = 32;
   localparam int DW = 4;
   localparam int LW = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } tb_beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ARVALID = 1'b0;
   logic          ARREADY;
   logic [AW-1:0] ARADDR = '0;
   logic [LW-1:0] ARLEN = '0;
   logic [2:0]    ARSIZE = '0;
   logic [1:0]    ARBURST = '0;
   logic          RVALID;
   logic          RREADY = 1'b0;
   logic [DW-1:0] RDATA;
   logic          RLAST;
   logic [1:0]    RRESP;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] mem [256];

   axi_slave_read_channel #(
      .ADDR_WIDTH(AW), .READ_CHANNEL_WIDTH(DW), .READ_BURST_LEN(LW), .MEM_DEPTH(256)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
      .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Read data is only meaningful the cycle after a strobe; otherwise it is garbage.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[7:0]];
      else           mem_rd_data <= DW'($urandom);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit out_of_range(input logic [AW-1:0] a);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
      return (a >= 32'd256);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic pick_ready(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return ((cyc % 3) == 1);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_arready"}, ARREADY, 0);
      check({tag, "_rvalid"}, RVALID, 0);
      check({tag, "_rlast"}, RLAST, 0);
      check({tag, "_rresp"}, RRESP, 0);
      check({tag, "_rdata"}, RDATA, 0);
      check({tag, "_rd_en"}, mem_rd_en, 0);
      check({tag, "_rd_addr"}, mem_rd_addr, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // One complete burst. abort_beat >= 0 asserts reset when that beat is presented.
   task automatic run_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input logic [1:0] burst, input int mode, input bit timed,
                            input int abort_beat);
      tb_beat_t      exp_q[$];
      logic [AW-1:0] addr_q[$];
      tb_beat_t      e, prev;
      logic [AW-1:0] a;
      bit            err, done, have_prev, visible;
      int            cyc, issued, popped, first_rv, last_cyc, pop;

      for (int k = 0; k <= int'(len); k++) begin
         a   = (burst == 2'b00) ? addr : addr + AW'(k);
         err = burst[1] || out_of_range(a);
         if (!err) addr_q.push_back(a);
         e.data = err ? '0 : mem[a[7:0]];
         e.resp = err ? 2'b10 : 2'b00;
         e.last = (k == int'(len));
         exp_q.push_back(e);
      end
      visible = (addr_q.size() == int'(len) + 1);

      @(negedge clk);
      check("arready_idle", ARREADY, 1);
      check("busy_idle", busy, 0);
      ARVALID = 1'b1;
      ARADDR  = addr;
      ARLEN   = len;
      ARBURST = burst;
      ARSIZE  = 3'($urandom);
      @(negedge clk);
      ARVALID = 1'b0;
      ARADDR  = AW'($urandom);
      ARLEN   = LW'($urandom);
      ARBURST = 2'($urandom);
      check("arready_busy", ARREADY, 0);
      check("busy_set", busy, 1);

      cyc = 1; issued = 0; popped = 0; first_rv = -1; last_cyc = -1;
      done = 0; have_prev = 0; prev = '0;
      while (!done && cyc < 300) begin
         RREADY = pick_ready(mode, cyc);
         #1;
         pop = (RVALID && RREADY) ? 1 : 0;
         if (burst[1]) check("rd_en_quiet", mem_rd_en, 0);
         if (mem_rd_en) begin
            if (addr_q.size() == 0) check("spurious_rd", 1, 0);
            else                    check("rd_addr", mem_rd_addr, addr_q.pop_front());
            if (visible) check("no_overissue", ((issued - popped - pop) < 2), 1);
            issued++;
         end
         if (have_prev) begin
            check("stall_rvalid", RVALID, 1);
            check("stall_stable", {RDATA, RRESP, RLAST}, prev);
         end
         if (RVALID) begin
            if (first_rv < 0) first_rv = cyc;
            if (abort_beat == popped) begin
               rst_n = 1'b0;
               #1;
               check_reset_outputs("mid_reset");
               return;
            end
            if (RREADY) begin
               if (exp_q.size() == 0) begin
                  check("extra_beat", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("rdata", RDATA, e.data);
                  check("rresp", RRESP, e.resp);
                  check("rlast", RLAST, e.last);
                  if (e.last) begin
                     done     = 1;
                     last_cyc = cyc;
                  end
               end
               popped++;
            end
         end
         have_prev = RVALID && !RREADY;
         prev      = {RDATA, RRESP, RLAST};
         @(negedge clk);
         cyc++;
      end
      RREADY = 1'b0;
      if (!done) check("burst_timeout", 0, 1);
      check("all_issued", addr_q.size(), 0);
      check("beat_count", popped, int'(len) + 1);
      if (timed) begin
         check("first_rvalid_cycle", first_rv, 3);
         check("last_hs_cycle", last_cyc, 2 + int'(len) + 1);
      end
      #1;
      check("arready_after", ARREADY, 1);
      check("busy_after", busy, 0);
      check("rvalid_after", RVALID, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = DW'(i);

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      #1;
      check("arready_before_clk", ARREADY, 0);
      @(negedge clk);
      check("arready_first_clk", ARREADY, 1);

      run_burst(32'h10, 8'd3, 2'b01, 0, 1, -1);
      run_burst(32'h5, 8'd2, 2'b00, 0, 1, -1);
      run_burst(32'h20, 8'd7, 2'b01, 1, 0, -1);
      run_burst(32'h40, 8'd1, 2'b10, 0, 1, -1);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
      run_burst(32'd254, 8'd3, 2'b01, 0, 1, -1);
`endif
      run_burst(32'hFFFF_FFFE, 8'd3, 2'b01, 2, 0, -1);

      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
      for (int n = 0; n < 10; n++) begin
         run_burst(AW'($urandom_range(0, 300)), LW'($urandom_range(0, 9)),
                   2'($urandom_range(0, 3)), 2, 0, -1);
      end

      run_burst(32'h30, 8'd7, 2'b01, 0, 0, 2);
      @(negedge clk);
      check_reset_outputs("held_reset");
      rst_n = 1'b1;
      @(negedge clk);
      run_burst(32'h60, 8'd0, 2'b01, 0, 1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axi_slave_read_channel.md
# axi_slave_read_channel

AXI read-channel slave that sits directly downstream of the master read channel. It accepts one AR request at a time, fetches the burst from a 1-cycle-latency synchronous memory read port, and returns the beats on the R channel. A 2-entry output buffer gives full throughput under RREADY back-pressure. It is the memory-side endpoint the master talks to in system and block-level benches.

## Interface
Parameters:
- ADDR_WIDTH, 32: width of ARADDR.
- READ_CHANNEL_WIDTH, 4: RDATA bits per beat; also the memory word width.
- READ_BURST_LEN, 8: width of ARLEN. A burst has ARLEN+1 beats.
- MEM_DEPTH, 256: number of memory words; used only under the range check.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address ready.
- ARADDR  in  ADDR_WIDTH  start word address (word-addressed).
- ARLEN  in  READ_BURST_LEN  beats minus one.
- ARSIZE  in  3  accepted and ignored.
- ARBURST  in  2  00 FIXED, 01 INCR; 10/11 unsupported.
- RVALID  out  1  read data valid.
- RREADY  in  1  master ready.
- RDATA  out  READ_CHANNEL_WIDTH  beat data.
- RLAST  out  1  last beat of the burst.
- RRESP  out  2  00 OKAY, 10 SLVERR.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  memory word address.
- mem_rd_data  in  READ_CHANNEL_WIDTH  valid in the cycle after mem_rd_en; not held afterwards.
- busy  out  1  high from AR acceptance until the RLAST handshake.

## Operation
- States: IDLE, BURST.
  - IDLE: ARREADY=1. When ARVALID&ARREADY, latch ARADDR, ARLEN, ARBURST, clear the issue and return counters, and go to BURST.
  - BURST: ARREADY=0. Leave for IDLE on the cycle RVALID&RREADY&RLAST handshakes.
- Issue rule: issue beat k when beats issued ≤ ARLEN and occ + inflight − pop < 2.
  - occ is buffer occupancy (0..2); inflight is 1 if an issue happened last cycle.
  - pop = RVALID&RREADY.
- Issue address:
  - INCR: base + k, wrapping modulo 2^ADDR_WIDTH.
  - FIXED: base for every beat.
- Unsupported ARBURST: every beat still follows the issue rule, but mem_rd_en=0 and the beat enters the buffer with data 0 and RRESP=10.
- Buffer: a 2-entry FIFO of {data, resp, last}.
  - RVALID = occ≠0; RDATA, RRESP and RLAST come from the head entry.
  - A push and a pop in the same cycle are both legal.
- RLAST is set on beat ARLEN only. A burst has exactly ARLEN+1 beats; ARLEN=0 gives a single beat with RLAST=1.
- RDATA, RRESP and RLAST hold stable while RVALID=1 and RREADY=0 (AXI rule).
- Reset, including mid-burst: clear the FSM, buffer and counters immediately. Any in-flight memory data is discarded.

## Timing
- Reset values: ARREADY=0 while rst_n is low, then 1 from the first clock after release. RVALID=0, RLAST=0, RRESP=00, RDATA=0, mem_rd_en=0, mem_rd_addr=0, busy=0.
- AR handshake in cycle T:
  - mem_rd_en for beat 0 is asserted in T+1.
  - The data is captured at the end of T+2.
  - RVALID=1 from T+3.
- With RREADY held high, one beat per cycle after the first. The last handshake of an N-beat burst is at T+2+N.
- The next ARREADY=1 is in the cycle after the RLAST handshake.
- RREADY low for M cycles: at most 2 beats are buffered, and issue stalls with no data loss.

## Configuration
- AXI_SLAVE_RANGE_CHECK_EN defined: a beat whose address is ≥ MEM_DEPTH gets mem_rd_en=0, data 0 and RRESP=10. In-range beats of the same burst return OKAY.
- Not defined: no range check. mem_rd_addr is driven unmodified and every supported beat returns RRESP=00.

## Test plan
- ARADDR=0x10, ARLEN=3, INCR, RREADY=1, mem[i]=i[3:0] → RVALID from T+3; beats 0,1,2,3 on consecutive cycles with RRESP=00; RLAST only on 0x3; ARREADY=1 the cycle after.
- ARADDR=0x5, ARLEN=2, FIXED → mem_rd_addr=0x5 three times; three beats of mem[5]; RLAST on the third.
- INCR ARLEN=7 with RREADY toggling 1,0,0,1,… → all 8 beats in order and stable while stalled; occ never exceeds 2; mem_rd_en never fires while occ+inflight−pop=2.
- ARBURST=10, ARLEN=1 → two beats with RDATA=0 and RRESP=10, RLAST on the second; mem_rd_en stays 0.
- With AXI_SLAVE_RANGE_CHECK_EN, ARADDR=254, ARLEN=3, INCR → beats 254 and 255 return OKAY; beats 256 and 257 return SLVERR with data 0.
- Drop rst_n during beat 2 of an 8-beat burst → all outputs at reset values immediately; after release a new ARLEN=0 read returns a single correct beat with RLAST=1.
